// File: rtl/frontend_dispatch.sv
// Instruction front-end slice: program counter, instruction fetch queue and an
// in-order dispatcher that steers each instruction into the INT, FP or AGU issue queue.

module frontend_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enq,
    input  logic [WIDTH-1:0] data_in,
    input  logic             deq,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_enq_s;
    logic             do_deq_s;

    // Status from registered occupancy; a full queue refuses enq even when it is popped that cycle.
    always_comb begin
        full     = (count_r == CW'(DEPTH));
        empty    = (count_r == {CW{1'b0}});
        do_enq_s = enq & ~full;
        do_deq_s = deq & ~empty;
        if (empty) begin
            data_out = {WIDTH{1'b0}};
        end else begin
            data_out = mem_r[rd_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (resetn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_enq_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_deq_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_enq_s, do_deq_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care while unoccupied, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_enq_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end
endmodule

module frontend_dispatch #(
    parameter int              XLEN      = 32,
    parameter int              IFQ_DEPTH = 4,
    parameter int              IQ_DEPTH  = 4,
    parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            pc_incr,
    input  logic            pc_load,
    input  logic [XLEN-1:0] pc_load_val,
    output logic [XLEN-1:0] pc,
    input  logic            enq_ifq,
    input  logic [XLEN-1:0] data_in_ifq,
    output logic            full_ifq,
    output logic            empty_ifq,
    input  logic            deq_intalu,
    input  logic            deq_fpalu,
    input  logic            deq_agu,
    output logic [XLEN-1:0] intalu_data_o,
    output logic [XLEN-1:0] fpalu_data_o,
    output logic [XLEN-1:0] agu_data_o,
    output logic            full_intalu,
    output logic            full_fpalu,
    output logic            full_agu,
    output logic            empty_intalu,
    output logic            empty_fpalu,
    output logic            empty_agu
);
    typedef enum logic [1:0] {
        UNIT_INT = 2'd0,
        UNIT_FP  = 2'd1,
        UNIT_AGU = 2'd2
    } unit_e;

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] ifq_head_s;
    unit_e           head_unit_s;
    logic            tgt_full_s;
    logic            dispatch_s;
    logic            push_int_s;
    logic            push_fp_s;
    logic            push_agu_s;

    // Memory ops go to the AGU, the FP op and fused multiply-add group to the FP ALU, all else to INT.
    function automatic unit_e classify_unit(input logic [6:0] opcode);
        unit_e unit;
        case (opcode)
            7'b0000011, 7'b0100011, 7'b0000111, 7'b0100111: unit = UNIT_AGU;
            7'b1010011, 7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: unit = UNIT_FP;
            default: unit = UNIT_INT;
        endcase
        return unit;
    endfunction

    // Program counter: load beats increment; increment wraps modulo 2^XLEN.
    always_ff @(posedge clk) begin
        if (resetn) begin
            pc_r <= RESET_PC;
        end else if (pc_load) begin
            pc_r <= pc_load_val;
        end else if (pc_incr) begin
            pc_r <= pc_r + XLEN'(4);
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc = pc_r;

    // Move the IFQ head into its target queue unless that queue is full; a stall blocks younger words.
    always_comb begin
        head_unit_s = classify_unit(ifq_head_s[6:0]);
        case (head_unit_s)
            UNIT_INT: tgt_full_s = full_intalu;
            UNIT_FP:  tgt_full_s = full_fpalu;
            UNIT_AGU: tgt_full_s = full_agu;
            default:  tgt_full_s = 1'b1;
        endcase
        dispatch_s = ~empty_ifq & ~tgt_full_s;
        push_int_s = dispatch_s & (head_unit_s == UNIT_INT);
        push_fp_s  = dispatch_s & (head_unit_s == UNIT_FP);
        push_agu_s = dispatch_s & (head_unit_s == UNIT_AGU);
    end

    frontend_fifo #(.WIDTH(XLEN), .DEPTH(IFQ_DEPTH)) u_ifq (
        .clk      (clk),
        .resetn   (resetn),
        .enq      (enq_ifq),
        .data_in  (data_in_ifq),
        .deq      (dispatch_s),
        .data_out (ifq_head_s),
        .full     (full_ifq),
        .empty    (empty_ifq)
    );

    frontend_fifo #(.WIDTH(XLEN), .DEPTH(IQ_DEPTH)) u_iq_int (
        .clk      (clk),
        .resetn   (resetn),
        .enq      (push_int_s),
        .data_in  (ifq_head_s),
        .deq      (deq_intalu),
        .data_out (intalu_data_o),
        .full     (full_intalu),
        .empty    (empty_intalu)
    );

    frontend_fifo #(.WIDTH(XLEN), .DEPTH(IQ_DEPTH)) u_iq_fp (
        .clk      (clk),
        .resetn   (resetn),
        .enq      (push_fp_s),
        .data_in  (ifq_head_s),
        .deq      (deq_fpalu),
        .data_out (fpalu_data_o),
        .full     (full_fpalu),
        .empty    (empty_fpalu)
    );

    frontend_fifo #(.WIDTH(XLEN), .DEPTH(IQ_DEPTH)) u_iq_agu (
        .clk      (clk),
        .resetn   (resetn),
        .enq      (push_agu_s),
        .data_in  (ifq_head_s),
        .deq      (deq_agu),
        .data_out (agu_data_o),
        .full     (full_agu),
        .empty    (empty_agu)
    );
endmodule

// File: tb/tb_frontend_dispatch.sv
// Self-checking bench for frontend_dispatch: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.

module tb_frontend_dispatch;
    localparam int          XLEN      = 32;
    localparam int          IFQ_DEPTH = 4;
    localparam int          IQ_DEPTH  = 4;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        resetn, pc_incr, pc_load, enq_ifq;
    logic        deq_intalu, deq_fpalu, deq_agu;
    logic [31:0] pc_load_val, data_in_ifq, pc;
    logic        full_ifq, empty_ifq;
    logic [31:0] intalu_data_o, fpalu_data_o, agu_data_o;
    logic        full_intalu, full_fpalu, full_agu;
    logic        empty_intalu, empty_fpalu, empty_agu;

    frontend_dispatch #(
        .XLEN(XLEN), .IFQ_DEPTH(IFQ_DEPTH), .IQ_DEPTH(IQ_DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .resetn(resetn), .pc_incr(pc_incr), .pc_load(pc_load),
        .pc_load_val(pc_load_val), .pc(pc), .enq_ifq(enq_ifq), .data_in_ifq(data_in_ifq),
        .full_ifq(full_ifq), .empty_ifq(empty_ifq), .deq_intalu(deq_intalu),
        .deq_fpalu(deq_fpalu), .deq_agu(deq_agu), .intalu_data_o(intalu_data_o),
        .fpalu_data_o(fpalu_data_o), .agu_data_o(agu_data_o), .full_intalu(full_intalu),
        .full_fpalu(full_fpalu), .full_agu(full_agu), .empty_intalu(empty_intalu),
        .empty_fpalu(empty_fpalu), .empty_agu(empty_agu)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_ifq[$];
    logic [31:0] m_int[$];
    logic [31:0] m_fp[$];
    logic [31:0] m_agu[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // 0 = INT, 1 = FP, 2 = AGU
    function automatic int unit_of(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (op inside {7'h03, 7'h23, 7'h07, 7'h27}) return 2;
        if (op inside {7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F}) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] head_or_zero(input logic [31:0] q[$]);
        if (q.size() == 0) return 32'h0;
        return q[0];
    endfunction

    task automatic model_edge();
        int          ifq_n;
        int          tgt;
        bit          disp;
        logic [31:0] w;
        if (resetn) begin
            m_pc = RESET_PC;
            m_ifq.delete(); m_int.delete(); m_fp.delete(); m_agu.delete();
        end else begin
            if (pc_load) m_pc = pc_load_val;
            else if (pc_incr) m_pc = m_pc + 32'd4;
            ifq_n = m_ifq.size();
            disp  = 1'b0;
            tgt   = 0;
            w     = 32'h0;
            if (ifq_n > 0) begin
                w   = m_ifq[0];
                tgt = unit_of(w);
                disp = (tgt == 0) ? (m_int.size() < IQ_DEPTH) :
                       (tgt == 1) ? (m_fp.size()  < IQ_DEPTH) : (m_agu.size() < IQ_DEPTH);
            end
            if (deq_intalu && m_int.size() > 0) void'(m_int.pop_front());
            if (deq_fpalu  && m_fp.size()  > 0) void'(m_fp.pop_front());
            if (deq_agu    && m_agu.size() > 0) void'(m_agu.pop_front());
            if (disp) begin
                void'(m_ifq.pop_front());
                if (tgt == 0) m_int.push_back(w);
                else if (tgt == 1) m_fp.push_back(w);
                else m_agu.push_back(w);
            end
            if (enq_ifq && ifq_n < IFQ_DEPTH) m_ifq.push_back(data_in_ifq);
        end
    endtask

    task automatic compare_all();
        check_val("pc", pc, m_pc);
        check_val("empty_ifq", {31'b0, empty_ifq}, {31'b0, m_ifq.size() == 0});
        check_val("full_ifq", {31'b0, full_ifq}, {31'b0, m_ifq.size() == IFQ_DEPTH});
        check_val("empty_intalu", {31'b0, empty_intalu}, {31'b0, m_int.size() == 0});
        check_val("full_intalu", {31'b0, full_intalu}, {31'b0, m_int.size() == IQ_DEPTH});
        check_val("empty_fpalu", {31'b0, empty_fpalu}, {31'b0, m_fp.size() == 0});
        check_val("full_fpalu", {31'b0, full_fpalu}, {31'b0, m_fp.size() == IQ_DEPTH});
        check_val("empty_agu", {31'b0, empty_agu}, {31'b0, m_agu.size() == 0});
        check_val("full_agu", {31'b0, full_agu}, {31'b0, m_agu.size() == IQ_DEPTH});
        check_val("intalu_data", intalu_data_o, head_or_zero(m_int));
        check_val("fpalu_data", fpalu_data_o, head_or_zero(m_fp));
        check_val("agu_data", agu_data_o, head_or_zero(m_agu));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        resetn = 1'b0; pc_incr = 1'b0; pc_load = 1'b0; enq_ifq = 1'b0;
        deq_intalu = 1'b0; deq_fpalu = 1'b0; deq_agu = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
    endtask

    function automatic logic [31:0] gen_word();
        logic [6:0]  ops [12];
        logic [31:0] w;
        ops = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h07, 7'h27, 7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h37};
        w = $urandom;
        if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 11)];
        return w;
    endfunction

    initial begin
        logic [31:0] got[$];
        logic [31:0] expq[$];
        int          deq_pct;

        idle();
        pc_load_val = 32'h0; data_in_ifq = 32'h0;
        m_pc = 32'h0;

        // Reset state
        do_reset();
        check_val("rst_pc", pc, RESET_PC);
        check_val("rst_data", intalu_data_o | fpalu_data_o | agu_data_o, 32'h0);

        // PC increment, load priority and wrap
        pc_incr = 1'b1;
        repeat (3) tick();
        check_val("pc_incr3", pc, 32'd12);
        pc_load = 1'b1; pc_load_val = 32'h0000_0100;
        tick();
        check_val("pc_load_prio", pc, 32'h0000_0100);
        pc_incr = 1'b0; pc_load_val = 32'hFFFF_FFFC;
        tick();
        pc_load = 1'b0; pc_incr = 1'b1;
        tick();
        check_val("pc_wrap", pc, 32'h0);
        pc_incr = 1'b0;

        // Classification and dispatch latency
        enq_ifq = 1'b1;
        data_in_ifq = 32'h0000_0013; tick();
        data_in_ifq = 32'h0000_2083; tick();
        data_in_ifq = 32'h0000_0053; tick();
        enq_ifq = 1'b0;
        tick();
        check_val("cls_int", intalu_data_o, 32'h0000_0013);
        check_val("cls_agu", agu_data_o, 32'h0000_2083);
        check_val("cls_fp", fpalu_data_o, 32'h0000_0053);
        check_val("ifq_drained", {31'b0, empty_ifq}, 32'd1);
        deq_intalu = 1'b1; deq_fpalu = 1'b1; deq_agu = 1'b1;
        tick();
        idle();

        // Full INT queue stalls the head and blocks the younger load
        enq_ifq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in_ifq = 32'h0000_0013 | (i << 20);
            tick();
        end
        data_in_ifq = 32'h0010_0013; tick();
        data_in_ifq = 32'h0000_2083; tick();
        enq_ifq = 1'b0;
        tick(); tick();
        check_val("stall_int_full", {31'b0, full_intalu}, 32'd1);
        check_val("stall_agu_empty", {31'b0, empty_agu}, 32'd1);
        check_val("stall_ifq_held", {31'b0, empty_ifq}, 32'd0);
        deq_intalu = 1'b1; tick(); deq_intalu = 1'b0;
        tick();
        check_val("stall_release_int", {31'b0, full_intalu}, 32'd1);
        check_val("stall_lw_waits", {31'b0, empty_agu}, 32'd1);
        tick();
        check_val("stall_lw_dispatched", agu_data_o, 32'h0000_2083);

        // IFQ overflow: 5th word dropped, order preserved
        do_reset();
        expq.delete();
        enq_ifq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in_ifq = 32'h0000_0013 | (i << 20);
            expq.push_back(data_in_ifq);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            data_in_ifq = 32'h0A00_0013 + (i << 12);
            if (i < 4) expq.push_back(data_in_ifq);
            tick();
        end
        enq_ifq = 1'b0;
        check_val("ifq_full", {31'b0, full_ifq}, 32'd1);
        got.delete();
        deq_intalu = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (!empty_intalu) got.push_back(intalu_data_o);
            tick();
        end
        deq_intalu = 1'b0;
        check_val("ovf_count", got.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            if (i < got.size()) check_val($sformatf("ovf_order%0d", i), got[i], expq[i]);
        end

        // Pop of an empty queue is ignored
        do_reset();
        deq_agu = 1'b1; tick(); deq_agu = 1'b0;
        check_val("deq_empty_flag", {31'b0, empty_agu}, 32'd1);
        check_val("deq_empty_data", agu_data_o, 32'h0);

        // Randomized traffic with varying drain pressure
        for (int phase = 0; phase < 6; phase++) begin
            deq_pct = 10 + phase * 18;
            for (int c = 0; c < 500; c++) begin
                resetn      = ($urandom_range(0, 199) == 0);
                pc_load     = ($urandom_range(0, 15) == 0);
                pc_incr     = $urandom_range(0, 1);
                pc_load_val = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
                enq_ifq     = ($urandom_range(0, 3) != 0);
                data_in_ifq = gen_word();
                deq_intalu  = ($urandom_range(0, 99) < deq_pct);
                deq_fpalu   = ($urandom_range(0, 99) < deq_pct);
                deq_agu     = ($urandom_range(0, 99) < deq_pct);
                tick();
            end
        end

        // Reset while queues hold data
        idle();
        pc_incr = 1'b1; enq_ifq = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in_ifq = gen_word();
            tick();
        end
        idle();
        resetn = 1'b1; pc_incr = 1'b1; pc_load = 1'b1; pc_load_val = 32'h1234_5678; enq_ifq = 1'b1;
        tick();
        idle();
        check_val("midrst_pc", pc, RESET_PC);
        check_val("midrst_empty",
                  {28'b0, empty_ifq, empty_intalu, empty_fpalu, empty_agu}, 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/frontend_dispatch.md
Name: frontend_dispatch

Overview:
- Instruction front-end slice containing the program counter, the instruction fetch queue (IFQ), a dispatcher and three issue queues.
- Fetched 32-bit instructions enter the IFQ in order.
- The dispatcher classifies the IFQ head by opcode and moves it, in order, into the integer-ALU, FP-ALU or address-generation (AGU) issue queue.
- Functional units consume from the issue queues.

Parameters:
- XLEN, 32, datapath/instruction and PC width.
- IFQ_DEPTH, 4, IFQ entries (power of two, >=2).
- IQ_DEPTH, 4, entries per issue queue (power of two, >=2).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- resetn  input  1  synchronous, active-high reset (1 = reset).
- pc_incr  input  1  advance PC by 4.
- pc_load  input  1  load PC from pc_load_val.
- pc_load_val  input  XLEN  PC load value.
- pc  output  XLEN  current PC.
- enq_ifq  input  1  push data_in_ifq into IFQ.
- data_in_ifq  input  XLEN  instruction word.
- full_ifq  output  1  IFQ full.
- empty_ifq  output  1  IFQ empty.
- deq_intalu / deq_fpalu / deq_agu  input  1 each  pop the respective issue queue.
- intalu_data_o / fpalu_data_o / agu_data_o  output  XLEN each  head of the respective issue queue.
- full_intalu / full_fpalu / full_agu  output  1 each  issue queue full.
- empty_intalu / empty_fpalu / empty_agu  output  1 each  issue queue empty.

Behaviour:
- Reset (resetn=1 at an edge): pc=RESET_PC; all queues emptied; empty_*=1, full_*=0; data outputs 0.
- PC:
  - pc_load has priority over pc_incr: pc<=pc_load_val.
  - Else if pc_incr: pc<=pc+4, wrapping modulo 2^XLEN.
  - Else the PC holds.
- Queues (IFQ and each issue queue) are synchronous FIFOs with occupancy counters; full/empty derive from registered occupancy.
  - Head data is show-ahead (combinational from storage); it reads 0 when empty.
  - enq when full: ignored, no overwrite, even if deq is asserted the same cycle.
  - deq when empty: ignored.
  - enq+deq when neither full nor empty: both performed; occupancy unchanged.
  - enq+deq when empty: enq only.
  - Pointers wrap modulo depth.
- Dispatch:
  - Every cycle, if the IFQ is non-empty and the target issue queue of the IFQ head is not full, the head is popped and pushed into the target queue on the same edge.
  - One instruction per cycle, strictly in order.
  - A full target stalls the head; younger entries are not bypassed.
- Dispatch latency: a word enqueued at edge N sits at the IFQ head after N. It is dispatched at edge N+1 and is visible at the issue-queue head after N+1.
- Simultaneous external enq_ifq and dispatch pop: both occur. A dispatch push and an external deq on the same issue queue follow the FIFO rules above.
- Classification on instruction bits [6:0]:
  - AGU: 0000011 LOAD, 0100011 STORE, 0000111 LOAD-FP, 0100111 STORE-FP.
  - FP-ALU: 1010011 OP-FP, 1000011, 1000111, 1001011, 1001111 (fused multiply-add family).
  - INT-ALU: every other opcode, including illegal ones.
- Instruction words pass through unmodified.
- Reset mid-operation discards all queued instructions and restores the PC; reset overrides all other inputs that cycle.

Test Plan:
- Reset, then pc_incr for 3 cycles -> pc=12. Then pc_load=1, pc_incr=1, pc_load_val=0x100 -> pc=0x100. Load pc=0xFFFFFFFC then incr -> pc=0.
- Enqueue 0x00000013 (addi), 0x00002083 (lw), 0x00000053 (fadd.s) on consecutive cycles. Each appears at its queue head 2 edges after its enq:
  - intalu_data_o=0x00000013.
  - agu_data_o=0x00002083.
  - fpalu_data_o=0x00000053.
  - After the last dispatch, empty_ifq=1.
- Fill the INT queue with 4 addi words, no deq_intalu, then enqueue addi + lw -> full_intalu=1. The IFQ head stalls, the lw is not dispatched and agu stays empty. Pulse deq_intalu once -> the stalled addi dispatches next cycle, then the lw.
- With all dispatch targets blocked, push 5 words into the IFQ -> full_ifq=1 after 4 and the 5th is dropped. Reading the queue out yields the first 4 in order.
- deq_agu on an empty queue -> no change, empty_agu=1, agu_data_o=0.
- Assert reset while queues hold data -> all empty_*=1 and pc=RESET_PC on the next edge.
